// File: rtl/cmd_rx_ext_pkg.sv
// Shared definitions for the command receiver: op codes, FSM states and the
// mreq record with its byte-count-parametrised pack/unpack helpers.
package cmd_rx_ext_pkg;

  localparam logic [7:0] START_BYTE_DEF = 8'hA5;
  localparam logic [7:0] CRC8_POLY      = 8'h07;

  localparam logic [2:0] OP_MREAD  = 3'd1;
  localparam logic [2:0] OP_MWRITE = 3'd2;
  localparam logic [2:0] OP_STALL  = 3'd7;

  // Widest mreq: 4 control bits + 2 wcount bytes + 4 address bytes.
  localparam int MREQ_MAX_W = 52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_WCNT,
    ST_ADDR,
    ST_CRC,
    ST_STALL
  } state_e;

  typedef struct packed {
    logic        wr;
    logic        aincr;
    logic [1:0]  wsize;
    logic [15:0] wcount;
    logic [31:0] addr;
  } mreq_t;

  function automatic logic [MREQ_MAX_W-1:0] mreq_pack(input mreq_t m,
                                                      input int wcnt_nbytes,
                                                      input int addr_nbytes);
    int aw;
    int cw;
    logic [MREQ_MAX_W-1:0] a;
    logic [MREQ_MAX_W-1:0] c;
    logic [MREQ_MAX_W-1:0] h;
    aw = 8 * addr_nbytes;
    cw = 8 * wcnt_nbytes;
    a  = MREQ_MAX_W'(m.addr) & ((MREQ_MAX_W'(1) << aw) - MREQ_MAX_W'(1));
    c  = (MREQ_MAX_W'(m.wcount) & ((MREQ_MAX_W'(1) << cw) - MREQ_MAX_W'(1))) << aw;
    h  = MREQ_MAX_W'({m.wr, m.aincr, m.wsize}) << (aw + cw);
    return a | c | h;
  endfunction

  function automatic mreq_t mreq_unpack(input logic [MREQ_MAX_W-1:0] v,
                                        input int wcnt_nbytes,
                                        input int addr_nbytes);
    int aw;
    int cw;
    logic [MREQ_MAX_W-1:0] h;
    mreq_t m;
    aw       = 8 * addr_nbytes;
    cw       = 8 * wcnt_nbytes;
    m.addr   = 32'(v & ((MREQ_MAX_W'(1) << aw) - MREQ_MAX_W'(1)));
    m.wcount = 16'((v >> aw) & ((MREQ_MAX_W'(1) << cw) - MREQ_MAX_W'(1)));
    h        = v >> (aw + cw);
    m.wsize  = h[1:0];
    m.aincr  = h[2];
    m.wr     = h[3];
    return m;
  endfunction

endpackage

// File: rtl/cmd_rx_ext_crc8.sv
// Combinational CRC-8 (poly 0x07, MSB first) update over one byte.
module crc8
  import cmd_rx_ext_pkg::*;
(
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] c;

  always_comb begin
    c = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/cmd_rx_ext.sv
// Byte-stream command receiver: parses START/OP/WCNT/ADDR/CRC packets and
// presents good memory requests through a single-entry valid/ready register.
module cmd_rx_ext
  import cmd_rx_ext_pkg::*;
#(
  parameter int         ADDR_NBYTES = 4,
  parameter int         WCNT_NBYTES = 1,
  parameter logic [7:0] START_BYTE  = START_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 0,
  localparam int        MREQ_W      = 4 + 8 * WCNT_NBYTES + 8 * ADDR_NBYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_err_crc,
  output logic              o_err_timeout,
  output logic [7:0]        o_err_count,
  output logic              o_mreq_valid,
  input  logic              i_mreq_ready,
  output logic [MREQ_W-1:0] o_mreq
);

  state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  crc_q, crc_d;
  logic [15:0] tmo_q, tmo_d;
  logic        err_crc_q, err_crc_d;
  logic        err_tmo_q, err_tmo_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        mreq_valid_q, mreq_valid_d;
  logic [MREQ_W-1:0] mreq_q, mreq_d;
  logic [2:0]  op_q, op_d;
  logic        aincr_q, aincr_d;
  logic [1:0]  wsize_q, wsize_d;
  logic [15:0] wcount_q, wcount_d;
  logic [31:0] addr_q, addr_d;

  logic       rx_ready;
  logic       accept;
  logic       tmo_run;
  logic       load;
  logic [7:0] crc_in;
  logic [7:0] crc_next;
  mreq_t      fields;

  // The CRC byte may only land when the output slot is free or draining now.
  assign rx_ready = !((state_q == ST_CRC && mreq_valid_q && !i_mreq_ready) ||
                      state_q == ST_STALL);
  assign accept   = i_rx_valid && rx_ready;
  assign tmo_run  = (state_q == ST_OP) || (state_q == ST_WCNT) ||
                    (state_q == ST_ADDR) || (state_q == ST_CRC);
  assign crc_in   = (state_q == ST_IDLE) ? 8'h00 : crc_q;

  assign fields = '{wr: (op_q == OP_MWRITE), aincr: aincr_q, wsize: wsize_q,
                    wcount: wcount_q, addr: addr_q};

  crc8 u_crc8 (
    .crc_i  (crc_in),
    .data_i (i_rx_data),
    .crc_o  (crc_next)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    crc_d        = crc_q;
    tmo_d        = tmo_q;
    op_d         = op_q;
    aincr_d      = aincr_q;
    wsize_d      = wsize_q;
    wcount_d     = wcount_q;
    addr_d       = addr_q;
    err_crc_d    = 1'b0;
    err_tmo_d    = 1'b0;
    load         = 1'b0;

    if (accept) begin
      tmo_d = '0;
    end else if (tmo_run && rx_ready) begin
      tmo_d = tmo_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && i_rx_data == START_BYTE) begin
          crc_d   = crc_next;
          state_d = ST_OP;
        end
      end
      ST_OP: begin
        if (accept) begin
          crc_d    = crc_next;
          op_d     = i_rx_data[2:0];
          aincr_d  = i_rx_data[3];
          wsize_d  = i_rx_data[5:4];
          wcount_d = '0;
          cnt_d    = '0;
          state_d  = ST_WCNT;
        end
      end
      ST_WCNT: begin
        if (accept) begin
          crc_d                       = crc_next;
          wcount_d[8*cnt_q[0] +: 8]   = i_rx_data;
          cnt_d                       = cnt_q + 2'd1;
          if (cnt_q == 2'(WCNT_NBYTES - 1)) begin
            cnt_d   = '0;
            addr_d  = '0;
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (accept) begin
          crc_d                = crc_next;
          addr_d[8*cnt_q +: 8] = i_rx_data;
          cnt_d                = cnt_q + 2'd1;
          if (cnt_q == 2'(ADDR_NBYTES - 1)) begin
            cnt_d   = '0;
            state_d = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        if (accept) begin
          crc_d   = crc_next;
          state_d = ST_IDLE;
          if (crc_next != 8'h00) begin
            err_crc_d = 1'b1;
          end else if (op_q == OP_MREAD || op_q == OP_MWRITE) begin
            load = 1'b1;
          end else if (op_q == OP_STALL) begin
            state_d = ST_STALL;
          end
        end
      end
      ST_STALL: state_d = ST_STALL;
      default:  state_d = ST_IDLE;
    endcase

    if (TIMEOUT_CYC > 0 && tmo_run && rx_ready && !accept &&
        tmo_q == 16'(TIMEOUT_CYC - 1)) begin
      state_d   = ST_IDLE;
      tmo_d     = '0;
      err_tmo_d = 1'b1;
    end

    err_count_d = err_count_q;
    if ((err_crc_d || err_tmo_d) && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end

    mreq_d       = mreq_q;
    mreq_valid_d = mreq_valid_q;
    if (load) begin
      mreq_d       = MREQ_W'(mreq_pack(fields, WCNT_NBYTES, ADDR_NBYTES));
      mreq_valid_d = 1'b1;
    end else if (mreq_valid_q && i_mreq_ready) begin
      mreq_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      crc_q        <= '0;
      tmo_q        <= '0;
      err_crc_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
      err_count_q  <= '0;
      mreq_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      tmo_q        <= tmo_d;
      err_crc_q    <= err_crc_d;
      err_tmo_q    <= err_tmo_d;
      err_count_q  <= err_count_d;
      mreq_valid_q <= mreq_valid_d;
    end
  end

  // NOTE: payload registers carry no reset; they are only observed behind a
  // valid flag or after the FSM has rewritten them.
  always_ff @(posedge clk) begin
    op_q     <= op_d;
    aincr_q  <= aincr_d;
    wsize_q  <= wsize_d;
    wcount_q <= wcount_d;
    addr_q   <= addr_d;
    mreq_q   <= mreq_d;
  end

  assign o_rx_ready    = rx_ready;
  assign o_err_crc     = err_crc_q;
  assign o_err_timeout = err_tmo_q;
  assign o_err_count   = err_count_q;
  assign o_mreq_valid  = mreq_valid_q;
  assign o_mreq        = mreq_q;

endmodule

// File: tb/tb_cmd_rx_ext.sv
// Directed bench for cmd_rx_ext: dut_a uses default parameters, dut_b uses
// 2 address bytes, 2 word-count bytes and a 10-cycle inter-byte timeout.
module tb_cmd_rx_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [7:0] rxd [2];
  logic       rxv [2];
  logic       rdy_a, rdy_b;
  logic       ecrc_a, ecrc_b, etmo_a, etmo_b;
  logic [7:0] ecnt_a, ecnt_b;
  logic       mv_a, mv_b, mrdy_a, mrdy_b;
  logic [43:0] mq_a;
  logic [35:0] mq_b;

  cmd_rx_ext dut_a (
    .clk(clk), .rst(rst_a), .i_rx_data(rxd[0]), .i_rx_valid(rxv[0]),
    .o_rx_ready(rdy_a), .o_err_crc(ecrc_a), .o_err_timeout(etmo_a),
    .o_err_count(ecnt_a), .o_mreq_valid(mv_a), .i_mreq_ready(mrdy_a),
    .o_mreq(mq_a)
  );

  cmd_rx_ext #(.ADDR_NBYTES(2), .WCNT_NBYTES(2), .TIMEOUT_CYC(10)) dut_b (
    .clk(clk), .rst(rst_b), .i_rx_data(rxd[1]), .i_rx_valid(rxv[1]),
    .o_rx_ready(rdy_b), .o_err_crc(ecrc_b), .o_err_timeout(etmo_b),
    .o_err_count(ecnt_b), .o_mreq_valid(mv_b), .i_mreq_ready(mrdy_b),
    .o_mreq(mq_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Handshake log for dut_a, sampled away from the active edge.
  int          cyc = 0;
  int          hs_cyc[$];
  logic [43:0] hs_val[$];
  always @(negedge clk) begin
    cyc++;
    if (mv_a && mrdy_a) begin
      hs_cyc.push_back(cyc);
      hs_val.push_back(mq_a);
    end
  end

  logic [7:0] pkt[$];

  // Reference CRC-8, poly 0x07, zero seed, over the current packet queue.
  function automatic logic [7:0] crc_ref();
    logic [7:0] c;
    c = 8'h00;
    foreach (pkt[k]) begin
      c = c ^ pkt[k];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic rdy(input int d);
    return (d == 0) ? rdy_a : rdy_b;
  endfunction

  // Present one byte from the falling edge, hold until accepted (bounded).
  task automatic send(input int d, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rxd[d] = b;
    rxv[d] = 1'b1;
    while (!rdy(d) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("rdy_wait", 64'(n), 64'd0);
    @(posedge clk);
    #1 rxv[d] = 1'b0;
  endtask

  task automatic send_body(input int d);
    foreach (pkt[k]) send(d, pkt[k]);
  endtask

  task automatic send_pkt(input int d, input logic [7:0] crc_xor);
    logic [7:0] c;
    c = crc_ref();
    send_body(d);
    send(d, c ^ crc_xor);
  endtask

  localparam logic [43:0] EXP1 = {1'b1, 1'b0, 2'b00, 8'h01, 32'h40302010};
  localparam logic [43:0] EXP2 = {1'b0, 1'b0, 2'b00, 8'h03, 32'h11223344};

  initial begin
    logic [7:0] c2;
    rst_a = 1'b1; rst_b = 1'b1;
    rxv[0] = 1'b0; rxv[1] = 1'b0; rxd[0] = 8'h00; rxd[1] = 8'h00;
    mrdy_a = 1'b0; mrdy_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0; rst_b = 1'b0;

    // Reset state
    check("rst_ready",  64'(rdy_a),  64'd1);
    check("rst_valid",  64'(mv_a),   64'd0);
    check("rst_errcrc", 64'(ecrc_a), 64'd0);
    check("rst_errtmo", 64'(etmo_a), 64'd0);
    check("rst_errcnt", 64'(ecnt_a), 64'd0);

    // Single good MWRITE, output held while consumer not ready
    pkt = '{8'hA5, 8'h02, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40};
    c2 = crc_ref();
    send_body(0);
    check("pre_crc_valid", 64'(mv_a), 64'd0);
    send(0, c2);
    check("good_valid", 64'(mv_a), 64'd1);
    check("good_mreq",  64'(mq_a), 64'(EXP1));
    repeat (3) @(posedge clk);
    #1;
    check("hold_valid", 64'(mv_a), 64'd1);
    check("hold_mreq",  64'(mq_a), 64'(EXP1));
    mrdy_a = 1'b1;
    @(posedge clk);
    #1;
    check("drained_valid", 64'(mv_a), 64'd0);
    mrdy_a = 1'b0;

    // Bad CRC
    send_pkt(0, 8'h01);
    check("bad_errcrc", 64'(ecrc_a), 64'd1);
    check("bad_errcnt", 64'(ecnt_a), 64'd1);
    check("bad_valid",  64'(mv_a),   64'd0);
    @(posedge clk);
    #1;
    check("bad_pulse_end", 64'(ecrc_a), 64'd0);

    // Back-to-back packets, second CRC byte stalled, then no-bubble drain
    hs_cyc.delete();
    hs_val.delete();
    send_pkt(0, 8'h00);
    pkt = '{8'hA5, 8'h01, 8'h03, 8'h44, 8'h33, 8'h22, 8'h11};
    c2 = crc_ref();
    send_body(0);
    @(negedge clk);
    rxd[0] = c2;
    rxv[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("b2b_stall_ready", 64'(rdy_a), 64'd0);
    check("b2b_first_valid", 64'(mv_a),  64'd1);
    check("b2b_first_mreq",  64'(mq_a),  64'(EXP1));
    @(posedge clk);
    #1 mrdy_a = 1'b1;
    @(posedge clk);
    #1 rxv[0] = 1'b0;
    check("b2b_second_valid", 64'(mv_a), 64'd1);
    check("b2b_second_mreq",  64'(mq_a), 64'(EXP2));
    @(posedge clk);
    #1;
    check("b2b_drained", 64'(mv_a), 64'd0);
    mrdy_a = 1'b0;
    check("b2b_hs_count", 64'(hs_cyc.size()), 64'd2);
    if (hs_cyc.size() >= 2) begin
      check("b2b_hs0_mreq", 64'(hs_val[0]), 64'(EXP1));
      check("b2b_hs1_mreq", 64'(hs_val[1]), 64'(EXP2));
      check("b2b_no_bubble", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
    end

    // STALL op locks the receiver until reset
    pkt = '{8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt(0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("stall_ready", 64'(rdy_a), 64'd0);
    check("stall_valid", 64'(mv_a),  64'd0);
    rst_a = 1'b1;
    @(posedge clk);
    #1 rst_a = 1'b0;
    check("unstall_ready",  64'(rdy_a),  64'd1);
    check("unstall_errcnt", 64'(ecnt_a), 64'd0);

    // Error counter saturation over 300 bad packets
    pkt = '{8'hA5, 8'h02, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40};
    for (int i = 0; i < 254; i++) send_pkt(0, 8'h01);
    check("errcnt_254", 64'(ecnt_a), 64'hFE);
    for (int i = 0; i < 46; i++) send_pkt(0, 8'h01);
    check("errcnt_sat", 64'(ecnt_a), 64'hFF);

    // 2/2-byte field layout
    pkt = '{8'hA5, 8'h01, 8'h34, 8'h12, 8'hCD, 8'hAB};
    send_pkt(1, 8'h00);
    check("b_valid", 64'(mv_b), 64'd1);
    check("b_mreq",  64'(mq_b), 64'h0_1234_ABCD);

    // Inter-byte timeout after the first address byte
    pkt = '{8'hA5, 8'h02, 8'h05, 8'h00, 8'h11};
    send_body(1);
    repeat (9) @(posedge clk);
    #1;
    check("tmo_early",  64'(etmo_b), 64'd0);
    @(posedge clk);
    #1;
    check("tmo_pulse",  64'(etmo_b), 64'd1);
    check("tmo_errcnt", 64'(ecnt_b), 64'd1);
    check("tmo_nomreq", 64'(mv_b),   64'd0);
    @(posedge clk);
    #1;
    check("tmo_pulse_end", 64'(etmo_b), 64'd0);

    pkt = '{8'hA5, 8'h39, 8'h02, 8'h00, 8'h78, 8'h56};
    send_pkt(1, 8'h00);
    check("post_tmo_valid", 64'(mv_b), 64'd1);
    check("post_tmo_mreq",  64'(mq_b), 64'h7_0002_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cmd_rx_ext.md
CMD_RX_EXT -- requirements
Module: cmd_rx_ext

Interface
REQ-001 Parameter ADDR_NBYTES, default 4; address bytes per packet, legal range 1..4.
REQ-002 Parameter WCNT_NBYTES, default 1; word-count bytes per packet, legal range 1..2.
REQ-003 Parameter START_BYTE, default 8'hA5; packet start marker.
REQ-004 Parameter TIMEOUT_CYC, default 0; inter-byte timeout in clk cycles, 0 = disabled, max 2^16-1.
REQ-005 Derived MREQ_W = 4 + 8*WCNT_NBYTES + 8*ADDR_NBYTES.
REQ-006 clk  in  1  clock; all logic posedge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 i_rx_data  in  8  rx byte.
REQ-009 i_rx_valid  in  1  rx byte valid.
REQ-010 o_rx_ready  out  1  rx byte accepted when valid&ready.
REQ-011 o_err_crc  out  1  one-cycle pulse on bad CRC.
REQ-012 o_err_timeout  out  1  one-cycle pulse on inter-byte timeout abort.
REQ-013 o_err_count  out  8  saturating count of CRC+timeout errors.
REQ-014 o_mreq_valid  out  1  mreq output valid.
REQ-015 i_mreq_ready  in  1  mreq consumer ready.
REQ-016 o_mreq  out  MREQ_W  {wr, aincr, wsize[1:0], wcount, addr}, MSB first.

Function
REQ-017 States: IDLE, OP, WCNT, ADDR, CRC, STALL; a byte counter indexes multi-byte fields (WCNT, ADDR) and advances on each accepted byte.
REQ-018 IDLE discards non-START_BYTE bytes (accepted, ignored); START_BYTE -> OP.
REQ-019 OP byte: op = bits[2:0], aincr = bit[3], wsize = bits[5:4]; bits[7:6] ignored; -> WCNT.
REQ-020 WCNT/ADDR bytes are little-endian (first byte = LSB); WCNT exits after WCNT_NBYTES bytes, ADDR after ADDR_NBYTES bytes.
REQ-021 CRC-8 via crc8 is computed over all bytes START through CRC; seed 0 at START; packet good iff residue == 8'h00.
REQ-022 CRC byte accepted: bad CRC -> o_err_crc pulse in the cycle after acceptance, then IDLE; good MREAD(3'd1)/MWRITE(3'd2) -> load output register, then IDLE; good STALL(3'd7) -> STALL; other good ops -> IDLE, no output.
REQ-023 Output register is single-entry: o_mreq_valid rises the cycle after the good CRC byte; it clears on valid&ready unless reloaded in the same cycle.
REQ-024 The receiver keeps accepting the next packet while the output is pending; o_rx_ready = 0 only in CRC state while output valid and not ready, and in STALL.
REQ-025 Output handshake and a new CRC-byte load in the same cycle: the old mreq is consumed and the new one is loaded, with no bubble.
REQ-026 o_mreq and o_mreq_valid are stable while valid and not ready.
REQ-027 Timeout (TIMEOUT_CYC>0): the idle counter resets on every accepted byte and runs in states OP..CRC; reaching TIMEOUT_CYC -> o_err_timeout pulse and return to IDLE. The counter is inactive in IDLE and STALL, and stalled cycles in CRC (ready=0) do not count.
REQ-028 o_err_count increments on each CRC or timeout error and saturates at 8'hFF; simultaneous events cannot occur.
REQ-029 STALL is terminal until rst; a pending output still drains in STALL.

Reset
REQ-030 Reset state: IDLE, o_mreq_valid=0, o_err_crc=0, o_err_timeout=0, o_err_count=0, CRC seed 0, timeout counter 0.
REQ-031 rst mid-packet or with output pending discards everything; o_mreq contents are don't-care while invalid.
REQ-032 o_rx_ready = 1 in the first cycle after reset.

Structure
REQ-033 Op codes, START_BYTE default and the mreq field pack/unpack functions (parametrised by byte counts) belong in the shared cmd package.
REQ-034 The existing crc8 (combinational) is instantiated once; no other sub-module.

Verification
REQ-035 Defaults; A5 02 01 10 20 30 40 +good CRC -> one mreq {wr=1, aincr=0, wsize=0, wcount=01, addr=40302010}, valid the cycle after the CRC byte.
REQ-036 Same packet with CRC^8'h01 -> o_err_crc pulse, o_err_count=1, no mreq.
REQ-037 Two back-to-back good packets, i_mreq_ready=0 -> second CRC byte stalled (ready=0); raising ready -> second mreq follows with no bubble.
REQ-038 TIMEOUT_CYC=10, stop after addr byte 1 for 10 cycles -> o_err_timeout pulse, IDLE; next packet decodes correctly.
REQ-039 ADDR_NBYTES=2, WCNT_NBYTES=2; A5 01 34 12 CD AB CRC -> wr=0, wcount=1234, addr=ABCD.
REQ-040 Good STALL packet -> o_rx_ready=0 permanently; rst -> ready=1; 300 bad-CRC packets -> o_err_count=FF.
